// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encoding for the pipeline stall controller
package pipeline_ctrl_pkg;

  localparam int STATE_W     = 2;
  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// rtl/pipeline_stall_controller_if.sv - stall sources in, freeze/flush controls out
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             stat_clr;
  logic             freeze_if;
  logic             bubble_id;
  logic             flush_if;
  logic             freeze_all;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output hazard_detected, branch_taken, mem_req, mem_ready, stat_clr,
    input  freeze_if, bubble_id, flush_if, freeze_all, state, stall_count
  );

  modport slave (
    input  hazard_detected, branch_taken, mem_req, mem_ready, stat_clr,
    output freeze_if, bubble_id, flush_if, freeze_all, state, stall_count
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - arbitrates mem wait > branch > hazard into
// freeze/bubble/flush controls; all controls are Mealy so stalls act in the same cycle.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_stall_controller_if.slave  ctrl
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   freeze_if_c, bubble_id_c, flush_if_c, freeze_all_c;
  logic                   mem_stall;

  assign mem_stall = ctrl.mem_req & ~ctrl.mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_if_c  = 1'b0;
    bubble_id_c  = 1'b0;
    flush_if_c   = 1'b0;
    freeze_all_c = 1'b0;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        // Once waiting, only mem_ready matters; mem_req may drop while frozen.
        if ((state_q == ST_MEM_WAIT) ? ~ctrl.mem_ready : mem_stall) begin
          freeze_all_c = 1'b1;
          freeze_if_c  = 1'b1;
          state_d      = ST_MEM_WAIT;
        end else if (ctrl.branch_taken) begin
          flush_if_c  = 1'b1;
          bubble_id_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
          if (ctrl.hazard_detected) begin
            freeze_if_c = 1'b1;
            bubble_id_c = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (mem_stall) begin
          freeze_all_c = 1'b1;
          freeze_if_c  = 1'b1;
        end else begin
          flush_if_c  = 1'b1;
          bubble_id_c = 1'b1;
          if (ctrl.branch_taken) begin
            flush_cnt_d = FLUSH_RELOAD;
            state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
          end else if (flush_cnt_q <= 1) begin
            flush_cnt_d = '0;
            state_d     = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  assign ctrl.freeze_if  = freeze_if_c  & ~rst;
  assign ctrl.bubble_id  = bubble_id_c  & ~rst;
  assign ctrl.flush_if   = flush_if_c   & ~rst;
  assign ctrl.freeze_all = freeze_all_c & ~rst;
  assign ctrl.state      = state_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctrl.stat_clr),
    .inc   (ctrl.freeze_if | ctrl.flush_if),
    .count (ctrl.stall_count)
  );

endmodule
